// File: rtl/crc32_pkg.sv
// Shared types and widths for the CRC32 Ethernet accelerator byte packer.
package crc32_pkg;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {IDLE, ACCUM, DROP} packer_state_t;
endpackage

// File: rtl/crc32_byte_packer.sv
// Packs a byte stream LSB-first into 32-bit framed words for the CRC engine; words are registered 1 cycle
// after the completing byte, s_ready is high whenever out of reset. Optional CRC32_PACKER_STATS_EN adds frame counters.
module crc32_byte_packer
  import crc32_pkg::*;
#(
  parameter int          MAX_WORDS = 380,
  parameter logic [7:0]  PAD_BYTE  = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        word_valid,
  output logic        word_sop,
  output logic        word_last,
  output logic [31:0] word_data,
  output logic [2:0]  word_bytes,
  output logic        word_err
`ifdef CRC32_PACKER_STATS_EN
  ,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_err
`endif
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  packer_state_t       state_q, state_nxt;
  logic [1:0]          lane_q, lane_nxt;
  logic [CNT_W-1:0]    wcnt_q, wcnt_nxt;
  logic [WORD_W-1:0]   hold_q, hold_nxt;

  logic                accept;
  logic [WORD_W-1:0]   asm_word;
  logic                emit_vld, emit_sop, emit_last, emit_err;
  logic [WORD_W-1:0]   emit_dat;
  logic [2:0]          emit_bytes;

  assign s_ready = ~reset;
  assign accept  = s_valid & s_ready;

  // Lanes below the current one come from the hold register, the current lane
  // is the incoming byte, and lanes above are padding for a short tail.
  always_comb begin
    asm_word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(lane_q))
        asm_word[i*BYTE_W +: BYTE_W] = hold_q[i*BYTE_W +: BYTE_W];
      else if (i == int'(lane_q))
        asm_word[i*BYTE_W +: BYTE_W] = s_data;
      else
        asm_word[i*BYTE_W +: BYTE_W] = PAD_BYTE;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    lane_nxt   = lane_q;
    wcnt_nxt   = wcnt_q;
    hold_nxt   = hold_q;
    emit_vld   = 1'b0;
    emit_sop   = 1'b0;
    emit_last  = 1'b0;
    emit_err   = 1'b0;
    emit_dat   = '0;
    emit_bytes = '0;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          hold_nxt[int'(lane_q)*BYTE_W +: BYTE_W] = s_data;
          if (s_last || lane_q == 2'd3) begin
            emit_vld   = 1'b1;
            emit_sop   = (wcnt_q == '0);
            emit_dat   = asm_word;
            emit_bytes = 3'(lane_q) + 3'd1;
            lane_nxt   = 2'd0;
            if (s_last) begin
              emit_last = 1'b1;
              wcnt_nxt  = '0;
              state_nxt = IDLE;
            end else if (wcnt_q == CNT_W'(MAX_WORDS - 1)) begin
              // Oversize frame: close it here and swallow the remainder.
              emit_last = 1'b1;
              emit_err  = 1'b1;
              wcnt_nxt  = '0;
              state_nxt = DROP;
            end else begin
              wcnt_nxt  = wcnt_q + CNT_W'(1);
              state_nxt = ACCUM;
            end
          end else begin
            lane_nxt  = lane_q + 2'd1;
            state_nxt = ACCUM;
          end
        end
      end
      DROP: begin
        if (accept && s_last)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q  <= '0;
      wcnt_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_nxt;
      lane_q  <= lane_nxt;
      wcnt_q  <= wcnt_nxt;
      hold_q  <= hold_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_valid <= 1'b0;
      word_sop   <= 1'b0;
      word_last  <= 1'b0;
      word_err   <= 1'b0;
      word_data  <= '0;
      word_bytes <= '0;
    end else begin
      word_valid <= emit_vld;
      word_sop   <= emit_sop;
      word_last  <= emit_last;
      word_err   <= emit_err;
      word_data  <= emit_dat;
      word_bytes <= emit_bytes;
    end
  end

`ifdef CRC32_PACKER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frames_ok  <= '0;
      frames_err <= '0;
    end else if (word_valid && word_last) begin
      if (word_err) begin
        if (frames_err != 16'hFFFF) frames_err <= frames_err + 16'd1;
      end else begin
        if (frames_ok != 16'hFFFF) frames_ok <= frames_ok + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_crc32_byte_packer.sv
// Randomized bench for crc32_byte_packer against a frame-level word model.
module tb_crc32_byte_packer;
  localparam int          MAXW = 4;
  localparam logic [7:0]  PAD  = 8'h00;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid, s_ready, s_last;
  logic [7:0]  s_data;
  logic        word_valid, word_sop, word_last, word_err;
  logic [31:0] word_data;
  logic [2:0]  word_bytes;
`ifdef CRC32_PACKER_STATS_EN
  logic [15:0] frames_ok, frames_err;
`endif

  crc32_byte_packer #(.MAX_WORDS(MAXW), .PAD_BYTE(PAD)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .word_valid(word_valid), .word_sop(word_sop), .word_last(word_last),
    .word_data(word_data), .word_bytes(word_bytes), .word_err(word_err)
`ifdef CRC32_PACKER_STATS_EN
    , .frames_ok(frames_ok), .frames_err(frames_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    logic        sop, last, err;
    logic [2:0]  bytes;
    int          seq;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] frm[$];
  int         acc[8192];
  int         seq = 0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         exp_ok = 0;
  int         exp_err = 0;
  bit         mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected words of one frame: ceil(len/4) words, LSB-first, tail padded;
  // frames longer than MAXW words are cut at word MAXW and flagged.
  task automatic plan_frame();
    int   len, nw, emit_w;
    exp_t e;
    len    = frm.size();
    nw     = (len + 3) / 4;
    emit_w = (nw > MAXW) ? MAXW : nw;
    for (int w = 0; w < emit_w; w++) begin
      e.dat = '0;
      for (int b = 0; b < 4; b++)
        e.dat[8*b +: 8] = (4*w + b < len) ? frm[4*w + b] : PAD;
      e.bytes = (w == nw - 1) ? 3'(len - 4*w) : 3'd4;
      e.sop   = (w == 0);
      e.last  = (w == emit_w - 1);
      e.err   = (nw > MAXW) && (w == emit_w - 1);
      e.seq   = seq + 4*w + int'(e.bytes) - 1;
      expq.push_back(e);
    end
    if (nw > MAXW) exp_err++; else exp_ok++;
  endtask

  task automatic send_frame(input int gap_pct);
    plan_frame();
    for (int i = 0; i < frm.size(); i++) begin
      if ($urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      s_valid = 1'b1;
      s_data  = frm[i];
      s_last  = (i == frm.size() - 1);
      @(posedge clk); #1;
      acc[seq % 8192] = cyc;
      seq++;
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rand_frame(input int len);
    frm = {};
    for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (word_valid) begin
        if (expq.size() == 0) begin
          check("spurious_word", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("data",    word_data,  e.dat);
          check("sop",     word_sop,   e.sop);
          check("last",    word_last,  e.last);
          check("err",     word_err,   e.err);
          check("bytes",   word_bytes, e.bytes);
          check("latency", cyc,        acc[e.seq % 8192]);
        end
      end else begin
        check("idle_flags", {word_sop, word_last, word_err}, 3'b000);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", word_valid, 0);
    check("rst_flags", {word_sop, word_last, word_err}, 0);
    check("rst_data",  word_data, 0);
    check("rst_bytes", word_bytes, 0);
    check("rst_ready", s_ready, 0);
`ifdef CRC32_PACKER_STATS_EN
    check("rst_stats", {frames_ok, frames_err}, 0);
`endif
    reset = 1'b0;
    mon_en = 1'b1;
    idle(2);
    check("ready_up", s_ready, 1);

    frm = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_frame(0); idle(3);
    frm = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send_frame(0); idle(3);
    frm = {8'h5A};
    send_frame(0); idle(3);
    rand_frame(20); send_frame(0); idle(2);
    rand_frame(6);  send_frame(0); idle(2);
    rand_frame(16); send_frame(30); idle(2);
    rand_frame(17); send_frame(0);
    rand_frame(3);  send_frame(0);
    rand_frame(1);  send_frame(0);
    rand_frame(9);  send_frame(0);
    idle(4);
    check("drain_directed", expq.size(), 0);

    // Reset mid-frame drops the partial word and clears the stats.
    s_valid = 1'b1; s_last = 1'b0; s_data = 8'h11;
    @(posedge clk); #1;
    s_data = 8'h22;
    @(posedge clk); #1;
    s_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("ready_in_reset", s_ready, 0);
    @(posedge clk); #1;
    check("valid_in_reset", word_valid, 0);
    reset = 1'b0;
    exp_ok = 0; exp_err = 0;
    idle(1);
    frm = {8'hC1, 8'hC2, 8'hC3, 8'hC4};
    send_frame(0); idle(3);
`ifdef CRC32_PACKER_STATS_EN
    check("stats_after_reset", frames_ok, 1);
`endif

    for (int f = 0; f < 80; f++) begin
      rand_frame($urandom_range(1, 22));
      send_frame($urandom_range(0, 40));
      if ($urandom_range(2) != 0) idle($urandom_range(1, 3));
    end
    idle(5);
    check("drain_final", expq.size(), 0);
`ifdef CRC32_PACKER_STATS_EN
    check("frames_ok",  frames_ok,  exp_ok);
    check("frames_err", frames_err, exp_err);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
